// File: rtl/easyaxi_mst_ar_pkg.sv
//------------------------------------------------------------------------------
// easyaxi_mst_ar_pkg : shared AXI define and width helper for the AR issuer
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

package easyaxi_mst_ar_pkg;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/easyaxi_mst_ar.sv
//------------------------------------------------------------------------------
// easyaxi_mst_ar : issues REQ_NUM incrementing AXI read addresses with optional gaps
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

module easyaxi_mst_ar
   import easyaxi_mst_ar_pkg::*;
#(
   parameter int                        AXI_ADDR_WIDTH = `AXI_ADDR_WIDTH,
   parameter int                        REQ_NUM        = 4,
   parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_START     = '0,
   parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_STEP      = 'h40,
   parameter int                        GAP_CYCLES     = 0,
   parameter int                        CNT_W          = $clog2(REQ_NUM + 1)
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   output logic                      axi_mst_arvalid,
   input  logic                      axi_mst_arready,
   output logic [AXI_ADDR_WIDTH-1:0] axi_mst_araddr,
   output logic [CNT_W-1:0]          req_cnt,
   output logic                      done
);

   localparam int GAP_W = cnt_width(GAP_CYCLES);

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_req  = 2'd1;
   localparam logic [1:0] c_st_gap  = 2'd2;
   localparam logic [1:0] c_st_done = 2'd3;

   localparam logic [CNT_W-1:0] c_last_cnt   = CNT_W'(REQ_NUM - 1);
   localparam logic [GAP_W-1:0] c_gap_reload = GAP_W'(GAP_CYCLES - 1);

   logic [1:0]                r_state;
   logic                      r_arvalid;
   logic [AXI_ADDR_WIDTH-1:0] r_araddr;
   logic [CNT_W-1:0]          r_req_cnt;
   logic                      r_done;
   logic [GAP_W-1:0]          r_gap_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= c_st_idle;
         r_arvalid <= 1'b0;
         r_araddr  <= '0;
         r_req_cnt <= '0;
         r_done    <= 1'b0;
         r_gap_cnt <= '0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (enable) begin
                  r_state   <= c_st_req;
                  r_arvalid <= 1'b1;
                  r_araddr  <= ADDR_START;
                  r_req_cnt <= '0;
                  r_done    <= 1'b0;
               end
            end
            c_st_req: begin
               // Valid is never retracted: enable only matters once accepted.
               if (axi_mst_arready) begin
                  r_req_cnt <= r_req_cnt + CNT_W'(1);
                  if (r_req_cnt == c_last_cnt) begin
                     r_state   <= c_st_done;
                     r_arvalid <= 1'b0;
                     r_done    <= 1'b1;
                  end else if (!enable) begin
                     r_state   <= c_st_idle;
                     r_arvalid <= 1'b0;
                  end else if (GAP_CYCLES == 0) begin
                     r_araddr  <= r_araddr + ADDR_STEP;
                  end else begin
                     r_state   <= c_st_gap;
                     r_arvalid <= 1'b0;
                     r_gap_cnt <= c_gap_reload;
                     r_araddr  <= r_araddr + ADDR_STEP;
                  end
               end
            end
            c_st_gap: begin
               if (!enable) begin
                  r_state <= c_st_idle;
               end else if (r_gap_cnt == '0) begin
                  r_state   <= c_st_req;
                  r_arvalid <= 1'b1;
               end else begin
                  r_gap_cnt <= r_gap_cnt - GAP_W'(1);
               end
            end
            default: begin
               if (!enable) begin
                  r_state <= c_st_idle;
                  r_done  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign axi_mst_arvalid = r_arvalid;
   assign axi_mst_araddr  = r_araddr;
   assign req_cnt         = r_req_cnt;
   assign done            = r_done;

endmodule

`default_nettype wire

// File: tb/tb_easyaxi_mst_ar.sv
//------------------------------------------------------------------------------
// tb_easyaxi_mst_ar : scoreboard bench for the AR issuer (three configurations)
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_easyaxi_mst_ar;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        en_a, rdy_a, vld_a, done_a;
   logic [31:0] addr_a;
   logic [2:0]  cnt_a;
   logic        en_b, rdy_b, vld_b, done_b;
   logic [31:0] addr_b;
   logic [2:0]  cnt_b;
   logic        en_c, rdy_c, vld_c, done_c;
   logic [31:0] addr_c;
   logic [1:0]  cnt_c;

   int checks   = 0;
   int failures = 0;

   logic [31:0] q_a[$];
   logic [31:0] q_b[$];
   logic [31:0] q_c[$];

   easyaxi_mst_ar #(.AXI_ADDR_WIDTH(32), .REQ_NUM(4), .ADDR_START(32'h100),
                    .ADDR_STEP(32'h40), .GAP_CYCLES(0)) u_dut_a (
      .clk(clk), .rst(rst), .enable(en_a),
      .axi_mst_arvalid(vld_a), .axi_mst_arready(rdy_a), .axi_mst_araddr(addr_a),
      .req_cnt(cnt_a), .done(done_a));

   easyaxi_mst_ar #(.AXI_ADDR_WIDTH(32), .REQ_NUM(4), .ADDR_START(32'h100),
                    .ADDR_STEP(32'h40), .GAP_CYCLES(2)) u_dut_b (
      .clk(clk), .rst(rst), .enable(en_b),
      .axi_mst_arvalid(vld_b), .axi_mst_arready(rdy_b), .axi_mst_araddr(addr_b),
      .req_cnt(cnt_b), .done(done_b));

   easyaxi_mst_ar #(.AXI_ADDR_WIDTH(32), .REQ_NUM(2), .ADDR_START(32'hFFFF_FFC0),
                    .ADDR_STEP(32'h40), .GAP_CYCLES(0)) u_dut_c (
      .clk(clk), .rst(rst), .enable(en_c),
      .axi_mst_arvalid(vld_c), .axi_mst_arready(rdy_c), .axi_mst_araddr(addr_c),
      .req_cnt(cnt_c), .done(done_c));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input int sel, input int lim, input string nm);
      logic d;
      int   n;
      d = 1'b0;
      n = 0;
      while (!d && n < lim) begin
         @(negedge clk);
         d = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
         n++;
      end
      chk(nm, {31'd0, d}, 32'd1);
   endtask

   // Monitor A: address scoreboard plus valid/address stability under stall
   logic        pv_a = 1'b0;
   logic [31:0] pa_a = '0;
   always @(negedge clk) begin
      if (rst) begin
         pv_a = 1'b0;
      end else begin
         if (pv_a) begin
            chk("a_valid_hold", {31'd0, vld_a}, 32'd1);
            chk("a_addr_hold", addr_a, pa_a);
         end
         if (vld_a && rdy_a) begin
            if (q_a.size() == 0) chk("a_unexpected_accept", addr_a, 32'hDEAD_BEEF);
            else chk("a_addr", addr_a, q_a.pop_front());
         end
         pv_a = vld_a && !rdy_a;
         pa_a = addr_a;
      end
   end

   always @(negedge clk) begin
      if (!rst && vld_b && rdy_b) begin
         if (q_b.size() == 0) chk("b_unexpected_accept", addr_b, 32'hDEAD_BEEF);
         else chk("b_addr", addr_b, q_b.pop_front());
      end
   end

   always @(negedge clk) begin
      if (!rst && vld_c && rdy_c) begin
         if (q_c.size() == 0) chk("c_unexpected_accept", addr_c, 32'hDEAD_BEEF);
         else chk("c_addr", addr_c, q_c.pop_front());
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] gap_pat;
      logic       acc;
      int         busy;
      int         n;

      rst = 1'b1;
      en_a = 0; rdy_a = 0; en_b = 0; rdy_b = 0; en_c = 0; rdy_c = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_arvalid", {31'd0, vld_a}, 32'd0);
      chk("rst_araddr", addr_a, 32'd0);
      chk("rst_req_cnt", {29'd0, cnt_a}, 32'd0);
      chk("rst_done", {31'd0, done_a}, 32'd0);
      tick();
      rst = 1'b0;

      // Back-to-back: four accepts on consecutive edges
      q_a.push_back(32'h100); q_a.push_back(32'h140);
      q_a.push_back(32'h180); q_a.push_back(32'h1C0);
      rdy_a = 1; en_a = 1;
      tick();
      @(negedge clk);
      chk("b2b_first_addr", addr_a, 32'h100);
      repeat (3) tick();
      @(negedge clk);
      chk("b2b_done_not_early", {31'd0, done_a}, 32'd0);
      tick();
      @(negedge clk);
      chk("b2b_done", {31'd0, done_a}, 32'd1);
      chk("b2b_req_cnt", {29'd0, cnt_a}, 32'd4);
      chk("b2b_arvalid_low", {31'd0, vld_a}, 32'd0);
      chk("b2b_all_accepted", q_a.size(), 32'd0);
      en_a = 0;
      tick();
      @(negedge clk);
      chk("done_cleared", {31'd0, done_a}, 32'd0);
      chk("req_cnt_held", {29'd0, cnt_a}, 32'd4);

      // Backpressure during the second request
      tick();
      q_a.push_back(32'h100); q_a.push_back(32'h140);
      q_a.push_back(32'h180); q_a.push_back(32'h1C0);
      en_a = 1; rdy_a = 1;
      tick();
      tick();
      rdy_a = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_valid", {31'd0, vld_a}, 32'd1);
         chk("bp_addr", addr_a, 32'h140);
         tick();
      end
      rdy_a = 1;
      wait_done(0, 10, "bp_done");
      chk("bp_req_cnt", {29'd0, cnt_a}, 32'd4);
      chk("bp_all_accepted", q_a.size(), 32'd0);
      en_a = 0;
      tick();

      // Abort while valid is stalled: valid held until accept, then IDLE
      tick();
      q_a.push_back(32'h100);
      en_a = 1; rdy_a = 1;
      tick();
      tick();
      rdy_a = 0; en_a = 0;
      repeat (2) begin
         @(negedge clk);
         chk("abort_valid_held", {31'd0, vld_a}, 32'd1);
         tick();
      end
      q_a.push_back(32'h140);
      rdy_a = 1;
      tick();
      @(negedge clk);
      chk("abort_arvalid", {31'd0, vld_a}, 32'd0);
      chk("abort_req_cnt", {29'd0, cnt_a}, 32'd2);
      chk("abort_done", {31'd0, done_a}, 32'd0);
      tick();
      @(negedge clk);
      chk("abort_stays_idle", {31'd0, vld_a}, 32'd0);
      rdy_a = 0;

      // Asynchronous reset while arvalid is high
      tick();
      en_a = 1;
      tick();
      @(negedge clk);
      chk("pre_rst_valid", {31'd0, vld_a}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_arvalid", {31'd0, vld_a}, 32'd0);
      chk("async_rst_araddr", addr_a, 32'd0);
      en_a = 0;
      tick();
      tick();
      rst = 1'b0;

      // Paired with a slave that stalls two cycles after each accept
      q_a.push_back(32'h100); q_a.push_back(32'h140);
      q_a.push_back(32'h180); q_a.push_back(32'h1C0);
      en_a = 1; rdy_a = 1; busy = 0; n = 0;
      while (!done_a && n < 60) begin
         @(negedge clk);
         acc = vld_a & rdy_a;
         @(posedge clk);
         #1;
         if (acc) busy = 2;
         if (busy > 0) begin
            rdy_a = 0;
            busy--;
         end else begin
            rdy_a = 1;
         end
         n++;
      end
      chk("slave_done", {31'd0, done_a}, 32'd1);
      chk("slave_req_cnt", {29'd0, cnt_a}, 32'd4);
      chk("slave_all_accepted", q_a.size(), 32'd0);
      en_a = 0; rdy_a = 0;
      tick();

      // Gap of two idle cycles between accepts
      q_b.push_back(32'h100); q_b.push_back(32'h140);
      q_b.push_back(32'h180); q_b.push_back(32'h1C0);
      gap_pat = 10'b1001001001;
      en_b = 1; rdy_b = 1;
      for (int i = 0; i < 10; i++) begin
         tick();
         @(negedge clk);
         chk($sformatf("gap_valid_%0d", i), {31'd0, vld_b}, {31'd0, gap_pat[9-i]});
      end
      tick();
      @(negedge clk);
      chk("gap_done", {31'd0, done_b}, 32'd1);
      chk("gap_req_cnt", {29'd0, cnt_b}, 32'd4);
      chk("gap_all_accepted", q_b.size(), 32'd0);
      en_b = 0;
      tick();
      tick();

      // Enable dropped during GAP returns to IDLE on the next edge
      q_b.push_back(32'h100);
      en_b = 1;
      tick();
      tick();
      en_b = 0;
      tick();
      @(negedge clk);
      chk("gap_abort_req_cnt", {29'd0, cnt_b}, 32'd1);
      chk("gap_abort_done", {31'd0, done_b}, 32'd0);
      repeat (3) begin
         chk("gap_abort_idle", {31'd0, vld_b}, 32'd0);
         tick();
         @(negedge clk);
      end
      rdy_b = 0;

      // Address wrap-around at 2^32
      tick();
      q_c.push_back(32'hFFFF_FFC0); q_c.push_back(32'h0000_0000);
      en_c = 1; rdy_c = 1;
      wait_done(2, 10, "wrap_done");
      chk("wrap_req_cnt", {30'd0, cnt_c}, 32'd2);
      chk("wrap_all_accepted", q_c.size(), 32'd0);
      en_c = 0;
      tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
